// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the fetch stage.
//   XLEN          : integer register / PC width
//   NOP_INSTR     : canonical NOP (addi x0,x0,0) shown to decode when idle
//   fetch_entry_t : one fetched instruction tagged with its PC
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus.
//   ImemReq    : fetch request valid (master -> slave)
//   ImemAddr   : fetch address (master -> slave)
//   ImemGnt    : request accepted this cycle (slave -> master)
//   ImemRvalid : response word valid, in order (slave -> master)
//   ImemRdata  : response instruction word (slave -> master)
interface fetch_stage_if;
  import riscv_pkg::*;

  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemGnt;
  logic            ImemRvalid;
  logic [XLEN-1:0] ImemRdata;

  modport master (
    output ImemReq, ImemAddr,
    input  ImemGnt, ImemRvalid, ImemRdata
  );

  modport slave (
    input  ImemReq, ImemAddr,
    output ImemGnt, ImemRvalid, ImemRdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, instr} entries.
//   clk, rst      : clock, asynchronous active-high reset
//   flush_i       : empty the FIFO; overrides push/pop that cycle
//   push_i/wdata_i: write an entry (ignored when full)
//   pop_i         : retire the head entry (ignored when empty)
//   head_o        : current head entry, combinational
//   full_o/empty_o: occupancy flags
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign head_o  = mem[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are power-of-two sized, so they wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage.
//   clk, reset        : clock, asynchronous active-high reset
//   PCSrcE, PCTargetE : execute-stage redirect request and target
//   StallD            : decode holds its current instruction
//   imem (master)     : ImemReq/ImemAddr/ImemGnt/ImemRvalid/ImemRdata bus
//   InstrD, PCD,
//   PCPlus4D, ValidD  : FIFO head presented to decode (NOP/0/4/0 when empty)
// At most one request is in flight; a request is only issued when the FIFO
// has a free slot, so every granted word is guaranteed somewhere to land.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcE,
  input  logic [XLEN-1:0]  PCTargetE,
  input  logic             StallD,
  fetch_stage_if.master    imem,
  output logic [XLEN-1:0]  InstrD,
  output logic [XLEN-1:0]  PCD,
  output logic [XLEN-1:0]  PCPlus4D,
  output logic             ValidD
);

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;

  logic            fifo_full, fifo_empty;
  logic            fifo_push, fifo_pop;
  fetch_entry_t    fifo_wdata, fifo_head;
  logic            req_fire;
  logic            rsp_fire;

  assign imem.ImemReq  = ~reset & ~PCSrcE & ~outstanding_q & ~fifo_full;
  assign imem.ImemAddr = pcf_q;

  assign req_fire = imem.ImemReq & imem.ImemGnt;
  // A response with nothing outstanding (e.g. left over from before reset)
  // is not ours and is ignored.
  assign rsp_fire = imem.ImemRvalid & outstanding_q;

  assign fifo_wdata = '{pc: req_pc_q, instr: imem.ImemRdata};
  assign fifo_push  = rsp_fire & ~drop_q & ~PCSrcE;
  assign fifo_pop   = ValidD & ~StallD & ~PCSrcE;

  always_comb begin
    pcf_d         = pcf_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (rsp_fire) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end

    if (PCSrcE) begin
      // Masking the low bits keeps the new PC word-aligned.
      pcf_d = PCTargetE & ~32'h3;
      // A word still in flight belongs to the squashed path; mark it for
      // discard. Outstanding stays set until it returns so the new request
      // cannot overlap the stale response.
      drop_d = outstanding_q & ~imem.ImemRvalid;
    end else if (req_fire) begin
      req_pc_d      = pcf_q;
      pcf_d         = pcf_q + 32'd4;
      outstanding_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcf_q         <= RESET_PC;
      req_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      pcf_q         <= pcf_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (FETCH_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .flush_i (PCSrcE),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ValidD   = ~fifo_empty;
  assign InstrD   = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign PCD      = fifo_empty ? 32'h0     : fifo_head.pc;
  assign PCPlus4D = PCD + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        StallD = 1'b0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  fetch_stage_if imem_bus();

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .StallD    (StallD),
    .imem      (imem_bus.master),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_for(input logic [31:0] a);
    return 32'hB00C_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every instruction decode consumes must match the
  // next expected entry.
  always @(negedge clk) begin
    if (!reset && ValidD && !StallD && !PCSrcE) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected none", PCD, InstrD);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("PCD", PCD, e[63:32]);
        chk("InstrD", InstrD, e[31:0]);
        chk("PCPlus4D", PCPlus4D, e[63:32] + 32'd4);
        $display("consumed pc=%h instr=%h", PCD, InstrD);
      end
    end
  end

  // Grant one request expected at addr; respond one cycle later.
  task automatic do_grant(input logic [31:0] addr, input bit keep);
    bit seen;
    seen = 0;
    @(posedge clk); #1 imem_bus.ImemGnt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_bus.ImemReq) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no ImemReq expected request at %h", addr);
      imem_bus.ImemGnt = 1'b0;
      return;
    end
    chk("ImemAddr", imem_bus.ImemAddr, addr);
    @(posedge clk); #1;
    imem_bus.ImemGnt    = 1'b0;
    imem_bus.ImemRvalid = 1'b1;
    imem_bus.ImemRdata  = word_for(addr);
    if (keep) exp_q.push_back({addr, word_for(addr)});
    $display("fetch addr=%h keep=%0d", addr, keep);
    @(posedge clk); #1 imem_bus.ImemRvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_bus.ImemGnt    = 1'b0;
    imem_bus.ImemRvalid = 1'b0;
    imem_bus.ImemRdata  = 32'h0;

    // Reset state
    @(negedge clk);
    chk("rst_ImemReq", {31'b0, imem_bus.ImemReq}, 32'd0);
    chk("rst_ValidD", {31'b0, ValidD}, 32'd0);
    chk("rst_InstrD", InstrD, NOP_INSTR);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h4);
    @(posedge clk); #1 reset = 1'b0;

    // 1: sequential fetch
    do_grant(32'h0, 1);
    do_grant(32'h4, 1);
    do_grant(32'h8, 1);
    idle(3);
    chk("t1_drained", exp_q.size(), 0);

    // 2: decode stall fills FIFO, request stops, nothing lost
    StallD = 1'b1;
    do_grant(32'hC, 1);
    do_grant(32'h10, 1);
    repeat (6) begin
      @(negedge clk);
      chk("t2_req_blocked", {31'b0, imem_bus.ImemReq}, 32'd0);
      chk("t2_PCD_held", PCD, 32'hC);
      chk("t2_InstrD_held", InstrD, word_for(32'hC));
    end
    @(posedge clk); #1 StallD = 1'b0;
    idle(4);
    chk("t2_drained", exp_q.size(), 0);

    // 3: redirect with one entry queued and a request in flight
    StallD = 1'b1;
    do_grant(32'h14, 0);
    @(posedge clk); #1 imem_bus.ImemGnt = 1'b1;
    @(negedge clk);
    chk("t3_req", {31'b0, imem_bus.ImemReq}, 32'd1);
    chk("t3_addr", imem_bus.ImemAddr, 32'h18);
    @(posedge clk); #1;
    imem_bus.ImemGnt = 1'b0;
    PCSrcE = 1'b1;
    PCTargetE = 32'h100;
    @(negedge clk);
    chk("t3_req_forced0", {31'b0, imem_bus.ImemReq}, 32'd0);
    @(posedge clk); #1;
    PCSrcE = 1'b0;
    StallD = 1'b0;
    @(negedge clk);
    chk("t3_flushed", {31'b0, ValidD}, 32'd0);
    chk("t3_newpc", imem_bus.ImemAddr, 32'h100);
    @(posedge clk); #1;
    imem_bus.ImemRvalid = 1'b1;
    imem_bus.ImemRdata  = word_for(32'h18);
    @(posedge clk); #1 imem_bus.ImemRvalid = 1'b0;
    @(negedge clk);
    chk("t3_stale_dropped", {31'b0, ValidD}, 32'd0);
    do_grant(32'h100, 1);
    idle(3);
    chk("t3_drained", exp_q.size(), 0);

    // 4: redirect coinciding with response; target (misaligned) masked
    @(posedge clk); #1 imem_bus.ImemGnt = 1'b1;
    @(negedge clk);
    chk("t4_addr", imem_bus.ImemAddr, 32'h104);
    @(posedge clk); #1;
    imem_bus.ImemGnt    = 1'b0;
    imem_bus.ImemRvalid = 1'b1;
    imem_bus.ImemRdata  = word_for(32'h104);
    PCSrcE = 1'b1;
    PCTargetE = 32'h203;
    @(posedge clk); #1;
    imem_bus.ImemRvalid = 1'b0;
    PCSrcE = 1'b0;
    @(negedge clk);
    chk("t4_discarded", {31'b0, ValidD}, 32'd0);
    chk("t4_req_ready", {31'b0, imem_bus.ImemReq}, 32'd1);
    chk("t4_newpc", imem_bus.ImemAddr, 32'h200);
    do_grant(32'h200, 1);
    idle(3);

    // 5: grant withheld
    repeat (5) begin
      @(negedge clk);
      chk("t5_req", {31'b0, imem_bus.ImemReq}, 32'd1);
      chk("t5_addr", imem_bus.ImemAddr, 32'h204);
      chk("t5_ValidD", {31'b0, ValidD}, 32'd0);
      chk("t5_InstrD", InstrD, NOP_INSTR);
    end
    do_grant(32'h204, 1);
    idle(3);
    chk("t5_drained", exp_q.size(), 0);

    // 6: reset mid-transaction
    StallD = 1'b1;
    do_grant(32'h208, 0);
    @(posedge clk); #1 imem_bus.ImemGnt = 1'b1;
    @(negedge clk);
    chk("t6_addr", imem_bus.ImemAddr, 32'h20C);
    @(posedge clk); #1;
    imem_bus.ImemGnt = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_rst_ValidD", {31'b0, ValidD}, 32'd0);
    chk("t6_rst_pc", imem_bus.ImemAddr, 32'h0);
    chk("t6_rst_req", {31'b0, imem_bus.ImemReq}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    StallD = 1'b0;
    imem_bus.ImemRvalid = 1'b1;
    imem_bus.ImemRdata  = word_for(32'h20C);
    @(posedge clk); #1 imem_bus.ImemRvalid = 1'b0;
    @(negedge clk);
    chk("t6_stray_ignored", {31'b0, ValidD}, 32'd0);
    chk("t6_req", {31'b0, imem_bus.ImemReq}, 32'd1);
    chk("t6_addr_after", imem_bus.ImemAddr, 32'h0);
    do_grant(32'h0, 1);
    idle(4);
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
